// File: rtl/tanh_lut_loader.sv
// tanh_lut_loader: write-side companion of the tanh lookup table.
// Streams a full table of words into the single-port table memory, then
// hands the memory port over to the lookup path once the table is complete.
// The loader is the only owner of the memory port: load writes and
// forwarded lookups are muxed onto one registered request per cycle.
module tanh_lut_loader #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned SIM_DLY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load_start_pls,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_load_busy,
  output logic              o_load_done,
  output logic              o_err_pls,
  input  logic              i_rd_valid_pls,
  input  logic [ADDR_W-1:0] i_rd_x,
  output logic              o_rd_drop_pls,
  output logic              o_mem_rd_req,
  output logic              o_mem_wr_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wr_data
);

  // Loader states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Address of the final table entry; the beat landing here completes the load
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // SIM_DLY is kept so existing parameter overrides still elaborate; the
  // registered assignments carry no delay.
  if (SIM_DLY > 32'd1_000_000) begin : g_sim_dly_unused
  end

  // Registered state
  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] cnt_q,        cnt_d;
  logic              wr_req_q,     wr_req_d;
  logic              rd_req_q,     rd_req_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              err_pls_q,    err_pls_d;
  logic              drop_pls_q,   drop_pls_d;

  // Decoded conditions for the current cycle
  logic in_load;
  logic in_done;
  logic beat;
  logic last_beat;
  logic rd_accept;
  logic rd_reject;

  // Per-cycle handshake and arbitration decode
  always_comb begin
    in_load   = (state_q == ST_LOAD);
    in_done   = (state_q == ST_DONE);
    beat      = i_wr_valid & in_load;
    last_beat = beat & (cnt_q == LAST_ADDR);
    // A lookup only gets the port when the table is complete, the final
    // load write is not occupying the port, and no reload is starting.
    rd_accept = i_rd_valid_pls & in_done & ~wr_req_q & ~i_load_start_pls;
    rd_reject = i_rd_valid_pls & ~rd_accept;
  end

  // Next-state logic for FSM and load address counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load_start_pls) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        // Restart requests are ignored here; the load keeps its position.
        if (beat) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (last_beat) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: begin
        if (i_load_start_pls) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory request mux: load write has priority; the two are exclusive by state
  always_comb begin
    wr_req_d = 1'b0;
    rd_req_d = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    if (beat) begin
      wr_req_d = 1'b1;
      addr_d   = cnt_q;
      wdata_d  = i_wr_data;
    end else if (rd_accept) begin
      rd_req_d = 1'b1;
      addr_d   = i_rd_x;
    end
  end

  // Status pulses: start during load and rejected lookups
  always_comb begin
    err_pls_d  = i_load_start_pls & in_load;
    drop_pls_d = rd_reject;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_pls_q  <= 1'b0;
      drop_pls_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_pls_q  <= err_pls_d;
      drop_pls_q <= drop_pls_d;
    end
  end

  assign o_wr_ready    = in_load;
  assign o_load_busy   = in_load;
  assign o_load_done   = in_done;
  assign o_err_pls     = err_pls_q;
  assign o_rd_drop_pls = drop_pls_q;
  assign o_mem_rd_req  = rd_req_q;
  assign o_mem_wr_req  = wr_req_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wr_data = wdata_q;

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Directed testbench for tanh_lut_loader: full loads, gapped loads,
// lookup arbitration, reload, start-during-load and mid-load reset.
module tb_tanh_lut_loader;

  localparam int unsigned DATA_W = 14;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 16384;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              i_load_start_pls = 1'b0;
  logic              i_wr_valid = 1'b0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              o_wr_ready;
  logic              o_load_busy;
  logic              o_load_done;
  logic              o_err_pls;
  logic              i_rd_valid_pls = 1'b0;
  logic [ADDR_W-1:0] i_rd_x = '0;
  logic              o_rd_drop_pls;
  logic              o_mem_rd_req;
  logic              o_mem_wr_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wr_data;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  tanh_lut_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SIM_DLY(1)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_load_start_pls(i_load_start_pls),
    .i_wr_valid      (i_wr_valid),
    .i_wr_data       (i_wr_data),
    .o_wr_ready      (o_wr_ready),
    .o_load_busy     (o_load_busy),
    .o_load_done     (o_load_done),
    .o_err_pls       (o_err_pls),
    .i_rd_valid_pls  (i_rd_valid_pls),
    .i_rd_x          (i_rd_x),
    .o_rd_drop_pls   (o_rd_drop_pls),
    .o_mem_rd_req    (o_mem_rd_req),
    .o_mem_wr_req    (o_mem_wr_req),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wr_data   (o_mem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input int unsigned i);
    return DATA_W'(i) ^ 14'h155;
  endfunction

  function automatic logic [34:0] all_outs();
    return {o_wr_ready, o_load_busy, o_load_done, o_err_pls, o_rd_drop_pls,
            o_mem_rd_req, o_mem_wr_req, o_mem_addr, o_mem_wr_data};
  endfunction

  // Streams DEPTH words from the negedge after a start pulse. Every cycle the
  // memory port is checked against the beat driven one cycle earlier.
  // Returns after checking the final write (first DONE cycle).
  task automatic run_load(input bit gaps, input int unsigned err_at, input int unsigned rd_at,
                          output int unsigned bad, output int unsigned busy_cyc,
                          output int unsigned n_err, output int unsigned n_drop,
                          output int unsigned n_wr, output int unsigned n_done);
    int unsigned idx = 0;
    int unsigned budget = 0;
    bit prev_beat = 1'b0;
    bit err_sent = 1'b0;
    bit rd_sent = 1'b0;
    bit v;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    bad = 0; busy_cyc = 0; n_err = 0; n_drop = 0; n_wr = 0; n_done = 0;
    while ((idx < DEPTH || prev_beat) && budget < 4 * DEPTH) begin
      @(negedge clk);
      budget++;
      if (o_mem_rd_req !== 1'b0) bad++;
      if (prev_beat) begin
        if (o_mem_wr_req !== 1'b1 || o_mem_addr !== prev_addr || o_mem_wr_data !== prev_data) begin
          if (bad < 3)
            $display("  write idx %0d: req=%b addr=%h data=%h want addr=%h data=%h",
                     prev_addr, o_mem_wr_req, o_mem_addr, o_mem_wr_data, prev_addr, prev_data);
          bad++;
        end
      end else if (o_mem_wr_req !== 1'b0 || o_mem_wr_data !== '0) begin
        bad++;
      end
      if (o_mem_wr_req === 1'b1) n_wr++;
      if (o_load_busy === 1'b1) busy_cyc++;
      if (o_err_pls === 1'b1) n_err++;
      if (o_rd_drop_pls === 1'b1) n_drop++;
      if (o_load_done === 1'b1) n_done++;
      i_load_start_pls = 1'b0;
      i_rd_valid_pls   = 1'b0;
      prev_beat        = 1'b0;
      if (idx < DEPTH) begin
        v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        i_wr_valid = v;
        i_wr_data  = v ? word_of(idx) : DATA_W'($urandom);
        if (!err_sent && idx == err_at) begin
          i_load_start_pls = 1'b1;
          err_sent = 1'b1;
        end
        if (!rd_sent && idx == rd_at) begin
          i_rd_valid_pls = 1'b1;
          i_rd_x = 14'h0400;
          rd_sent = 1'b1;
        end
        if (v) begin
          prev_beat = 1'b1;
          prev_addr = ADDR_W'(idx);
          prev_data = word_of(idx);
          idx++;
        end
      end else begin
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
      end
    end
    if (budget >= 4 * DEPTH) begin
      $display("  load did not complete within %0d cycles", budget);
      bad++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (all_outs() !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rstn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (all_outs() !== 35'h0) begin
      tests_failed++;
      $display("FAIL idle_outputs: got %h expected 0", all_outs());
    end
    // write valid and lookup while idle
    i_wr_valid = 1'b1; i_wr_data = 14'h3fff;
    i_rd_valid_pls = 1'b1; i_rd_x = 14'h0123;
    @(negedge clk);
    i_wr_valid = 1'b0; i_rd_valid_pls = 1'b0;
    tests_run++;
    if ({o_rd_drop_pls, o_mem_rd_req, o_mem_wr_req, o_err_pls, o_load_busy} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL idle_lookup_drop: got drop/rd/wr/err/busy=%b expected 10000",
               {o_rd_drop_pls, o_mem_rd_req, o_mem_wr_req, o_err_pls, o_load_busy});
    end
    @(negedge clk);
    tests_run++;
    if (o_rd_drop_pls !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_single_cycle: got %b expected 0", o_rd_drop_pls);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned bad, busy, nerr, ndrop, nwr, ndone;
    @(negedge clk);
    i_load_start_pls = 1'b1;
    run_load(1'b0, DEPTH, DEPTH, bad, busy, nerr, ndrop, nwr, ndone);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL b2b_write_seq: got %0d bad cycles expected 0", bad);
    end
    tests_run++;
    if (nwr !== DEPTH || busy !== DEPTH) begin
      tests_failed++;
      $display("FAIL b2b_counts: got writes=%0d busy=%0d expected %0d/%0d", nwr, busy, DEPTH, DEPTH);
    end
    tests_run++;
    if (nerr !== 0 || ndrop !== 0 || ndone !== 1) begin
      tests_failed++;
      $display("FAIL b2b_pulses: got err=%0d drop=%0d done=%0d expected 0/0/1", nerr, ndrop, ndone);
    end
    tests_run++;
    if ({o_load_done, o_load_busy, o_wr_ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_done_state: got done/busy/ready=%b expected 100",
               {o_load_done, o_load_busy, o_wr_ready});
    end
    // lookup in the first DONE cycle collides with the last write
    i_rd_valid_pls = 1'b1; i_rd_x = 14'h0400;
    @(negedge clk);
    i_rd_valid_pls = 1'b0;
    tests_run++;
    if ({o_rd_drop_pls, o_mem_rd_req} !== 2'b10) begin
      tests_failed++;
      $display("FAIL first_done_lookup: got drop/rd=%b expected 10", {o_rd_drop_pls, o_mem_rd_req});
    end
  endtask

  task automatic test_lookup();
    @(negedge clk);
    i_rd_valid_pls = 1'b1; i_rd_x = 14'h0400;
    @(negedge clk);
    i_rd_x = 14'h2abc;
    tests_run++;
    if ({o_mem_rd_req, o_mem_wr_req, o_rd_drop_pls, o_mem_addr, o_mem_wr_data} !== {3'b100, 14'h0400, 14'h0}) begin
      tests_failed++;
      $display("FAIL lookup_0400: got rd/wr/drop=%b addr=%h data=%h expected 100 0400 0000",
               {o_mem_rd_req, o_mem_wr_req, o_rd_drop_pls}, o_mem_addr, o_mem_wr_data);
    end
    @(negedge clk);
    i_rd_valid_pls = 1'b0;
    tests_run++;
    if ({o_mem_rd_req, o_rd_drop_pls, o_mem_addr} !== {2'b10, 14'h2abc}) begin
      tests_failed++;
      $display("FAIL lookup_b2b: got rd/drop=%b addr=%h expected 10 2abc",
               {o_mem_rd_req, o_rd_drop_pls}, o_mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if ({o_mem_rd_req, o_mem_wr_req, o_load_done} !== 3'b001) begin
      tests_failed++;
      $display("FAIL lookup_idle: got rd/wr/done=%b expected 001", {o_mem_rd_req, o_mem_wr_req, o_load_done});
    end
  endtask

  task automatic test_reload_gaps();
    int unsigned bad, busy, nerr, ndrop, nwr, ndone;
    // start and lookup together in DONE: start wins, lookup dropped
    @(negedge clk);
    i_load_start_pls = 1'b1;
    i_rd_valid_pls = 1'b1; i_rd_x = 14'h0400;
    run_load(1'b1, DEPTH, 777, bad, busy, nerr, ndrop, nwr, ndone);
    tests_run++;
    if (bad !== 0 || nwr !== DEPTH) begin
      tests_failed++;
      $display("FAIL gap_write_seq: got bad=%0d writes=%0d expected 0/%0d", bad, nwr, DEPTH);
    end
    tests_run++;
    if (ndrop !== 2 || nerr !== 0) begin
      tests_failed++;
      $display("FAIL gap_drops: got drop=%0d err=%0d expected 2/0", ndrop, nerr);
    end
    tests_run++;
    if (ndone !== 1 || busy < DEPTH) begin
      tests_failed++;
      $display("FAIL gap_reload_done: got done=%0d busy=%0d expected 1/>=%0d", ndone, busy, DEPTH);
    end
  endtask

  task automatic test_err_pulse();
    int unsigned bad, busy, nerr, ndrop, nwr, ndone;
    @(negedge clk);
    i_load_start_pls = 1'b1;
    run_load(1'b0, 100, DEPTH, bad, busy, nerr, ndrop, nwr, ndone);
    tests_run++;
    if (nerr !== 1) begin
      tests_failed++;
      $display("FAIL err_pulse: got %0d pulses expected 1", nerr);
    end
    tests_run++;
    if (bad !== 0 || nwr !== DEPTH || busy !== DEPTH || ndone !== 1) begin
      tests_failed++;
      $display("FAIL err_load_continues: got bad=%0d writes=%0d busy=%0d done=%0d expected 0/%0d/%0d/1",
               bad, nwr, busy, ndone, DEPTH, DEPTH);
    end
  endtask

  task automatic test_reset_mid_load();
    int unsigned leaks = 0;
    @(negedge clk);
    i_load_start_pls = 1'b1;
    @(negedge clk);
    i_load_start_pls = 1'b0;
    for (int unsigned i = 0; i < 5000; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = word_of(i);
      @(negedge clk);
    end
    tests_run++;
    if ({o_mem_wr_req, o_mem_addr, o_load_busy} !== {1'b1, 14'd4999, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_reset_write: got req=%b addr=%0d busy=%b expected 1 4999 1",
               o_mem_wr_req, o_mem_addr, o_load_busy);
    end
    rstn = 1'b0;
    #1;
    tests_run++;
    if (all_outs() !== 35'h0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %h expected 0", all_outs());
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_mem_wr_req !== 1'b0 || o_load_busy !== 1'b0 || o_wr_ready !== 1'b0 || o_load_done !== 1'b0)
        leaks++;
    end
    i_wr_valid = 1'b0;
    tests_run++;
    if (leaks !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_ignore: got %0d active cycles expected 0", leaks);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lookup();
    test_reload_gaps();
    test_err_pulse();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
